rtc_timekeeper: RTL

//   Parametrised BCD time-of-day counter (HH:MM:SS). Successor to the single-mode watch counter.
//   - Runs in the clk domain on a one-cycle seconds enable; no derived clock.
//   - Adds run/pause, a validated parallel preset, an edit path without carry, and a registered 12h view.
//   - Feeds the alarm comparator and the 7-segment display mux of the alarm-clock top.

---
 rtl/rtc_timekeeper.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_timekeeper.sv
// ---------------------------------------------------------------------------
// rtc_timekeeper
//   BCD time-of-day counter (HH:MM:SS, 24h internal) driven by a prescaled
//   one-cycle seconds enable in the clk domain. Supports run/pause, a
//   validated parallel preset, minute/hour edit buttons without carry and a
//   registered 12h display view.
//
//   Ports
//     clk           in   1   system clock, rising edge
//     reset         in   1   asynchronous active-low reset
//     run           in   1   1 = prescaler and time advance, 0 = frozen
//     edit_btns     in   2   [1] hour+1, [0] minute+1 (one-cycle pulses)
//     load          in   1   preset pulse, takes load_time if valid
//     load_time     in   20  24h BCD preset, same layout as current_time
//     mode_12h      in   1   display_time format select
//     current_time  out  20  {Ht[1:0],Hu[3:0],Mt[2:0],Mu[3:0],St[2:0],Su[3:0]}
//     display_time  out  20  current_time or its 12h form (one cycle later)
//     pm            out  1   hour >= 12 (same latency as display_time)
//     sec_tick      out  1   first cycle a new second is visible
//     day_wrap      out  1   with sec_tick on 23:59:59 -> 00:00:00
//     load_err      out  1   load rejected because of invalid BCD
// ---------------------------------------------------------------------------
module rtc_timekeeper #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_DIV    = CLK_FREQ_HZ,
   parameter int CW          = $clog2(TICK_DIV)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [1:0]  edit_btns,
   input  logic        load,
   input  logic [19:0] load_time,
   input  logic        mode_12h,
   output logic [19:0] current_time,
   output logic [19:0] display_time,
   output logic        pm,
   output logic        sec_tick,
   output logic        day_wrap,
   output logic        load_err
);

   localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
   localparam logic [19:0]   LAST_SEC   = {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9};

   // ------------------------------------------------------------------------
   // BCD helpers
   // ------------------------------------------------------------------------

   // {tens[2:0], units[3:0]} modulo-60 increment (minutes or seconds)
   function automatic logic [6:0] inc_mod60(input logic [6:0] v);
      logic [2:0] tens;
      logic [3:0] units;
      tens  = v[6:4];
      units = v[3:0];
      if (units == 4'd9) begin
         if (tens == 3'd5) return 7'd0;
         return {tens + 3'd1, 4'd0};
      end
      return {tens, units + 4'd1};
   endfunction

   // {tens[1:0], units[3:0]} modulo-24 hour increment
   function automatic logic [5:0] inc_hour(input logic [5:0] v);
      logic [1:0] tens;
      logic [3:0] units;
      tens  = v[5:4];
      units = v[3:0];
      if (tens == 2'd2 && units == 4'd3) return 6'd0;
      if (units == 4'd9) return {tens + 2'd1, 4'd0};
      return {tens, units + 4'd1};
   endfunction

   // One-second advance with full ripple carry into minutes and hours
   function automatic logic [19:0] advance(input logic [19:0] t);
      logic       sec_carry;
      logic       min_carry;
      logic [19:0] n;
      sec_carry = (t[3:0] == 4'd9) && (t[6:4] == 3'd5);
      min_carry = sec_carry && (t[10:7] == 4'd9) && (t[13:11] == 3'd5);
      n         = t;
      n[6:0]    = inc_mod60(t[6:0]);
      if (sec_carry) n[13:7]  = inc_mod60(t[13:7]);
      if (min_carry) n[19:14] = inc_hour(t[19:14]);
      return n;
   endfunction

   // Preset acceptance: every field a legal BCD digit within its range
   function automatic logic load_ok(input logic [19:0] t);
      logic [1:0] ht;
      logic [3:0] hu;
      ht = t[19:18];
      hu = t[17:14];
      return (ht <= 2'd2) && (hu <= 4'd9) && !((ht == 2'd2) && (hu > 4'd3)) &&
             (t[13:11] <= 3'd5) && (t[10:7] <= 4'd9) &&
             (t[6:4] <= 3'd5) && (t[3:0] <= 4'd9);
   endfunction

   // 24h hour -> 12h hour; 20..23 need a tens borrow (20->08 .. 23->11)
   function automatic logic [19:0] to_12h(input logic [19:0] t);
      logic [1:0] ht;
      logic [3:0] hu;
      logic [19:0] n;
      ht = t[19:18];
      hu = t[17:14];
      n  = t;
      if (ht == 2'd0 && hu == 4'd0) begin
         n[19:14] = {2'd1, 4'd2};
      end else if (ht == 2'd1 && hu >= 4'd3) begin
         n[19:14] = {2'd0, hu - 4'd2};
      end else if (ht == 2'd2) begin
         if (hu <= 4'd1) n[19:14] = {2'd0, hu + 4'd8};
         else            n[19:14] = {2'd1, hu - 4'd2};
      end
      return n;
   endfunction

   function automatic logic is_pm(input logic [19:0] t);
      return (t[19:18] == 2'd2) || ((t[19:18] == 2'd1) && (t[17:14] >= 4'd2));
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CW-1:0] r_presc;
   logic [19:0]   r_time;
   logic [19:0]   r_disp;
   logic          r_pm;
   logic          r_sec_tick;
   logic          r_day_wrap;
   logic          r_load_err;

   logic [CW-1:0] w_presc_nxt;
   logic [19:0]   w_time_nxt;
   logic          w_tick_nxt;
   logic          w_wrap_nxt;
   logic          w_err_nxt;

   // Priority load > edit > tick. A tick that loses is dropped, not queued.
   // A rejected load also blocks edit/tick for that cycle, so nothing moves.
   always_comb begin
      w_presc_nxt = r_presc;
      w_time_nxt  = r_time;
      w_tick_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (load) begin
         if (load_ok(load_time)) begin
            w_time_nxt  = load_time;
            w_presc_nxt = '0;
         end else begin
            w_err_nxt = 1'b1;
         end
      end else if (edit_btns != 2'b00) begin
         if (edit_btns[0]) w_time_nxt[13:7]  = inc_mod60(r_time[13:7]);
         if (edit_btns[1]) w_time_nxt[19:14] = inc_hour(r_time[19:14]);
         w_time_nxt[6:0] = 7'd0;
         w_presc_nxt     = '0;
      end else if (run) begin
         if (r_presc == PRESC_LAST) begin
            w_presc_nxt = '0;
            w_time_nxt  = advance(r_time);
            w_tick_nxt  = 1'b1;
            w_wrap_nxt  = (r_time == LAST_SEC);
         end else begin
            w_presc_nxt = r_presc + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc    <= '0;
         r_time     <= '0;
         r_sec_tick <= 1'b0;
         r_day_wrap <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_presc    <= w_presc_nxt;
         r_time     <= w_time_nxt;
         r_sec_tick <= w_tick_nxt;
         r_day_wrap <= w_wrap_nxt;
         r_load_err <= w_err_nxt;
      end
   end

   // Display view is registered from current_time, one cycle behind it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_disp <= '0;
         r_pm   <= 1'b0;
      end else begin
         r_disp <= mode_12h ? to_12h(r_time) : r_time;
         r_pm   <= is_pm(r_time);
      end
   end

   assign current_time = r_time;
   assign display_time = r_disp;
   assign pm           = r_pm;
   assign sec_tick     = r_sec_tick;
   assign day_wrap     = r_day_wrap;
   assign load_err     = r_load_err;

endmodule
